// File: rtl/hilo_sequencer.sv
// HI/LO sequencer: issues MULT/DIV start pulses, waits out the fixed
// unit latency, captures results into HI/LO, and executes MTHI/MTLO.
module hilo_sequencer #(
  parameter int MULT_LAT = 34,
  parameter int DIV_LAT  = 34
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [5:0] MULT_LAST = 6'(MULT_LAT - 1);
  localparam logic [5:0] DIV_LAST  = 6'(DIV_LAT - 1);

  state_t      state, state_n;
  logic [5:0]  cnt, cnt_n;
  logic        sel, sel_n;
  logic [31:0] hi_n, lo_n, ua_n, ub_n;
  logic        done_n, dz_n;
  logic [5:0]  last;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      sel      <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      unit_a   <= '0;
      unit_b   <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      sel      <= sel_n;
      hi_out   <= hi_n;
      lo_out   <= lo_n;
      unit_a   <= ua_n;
      unit_b   <= ub_n;
      done     <= done_n;
      div_zero <= dz_n;
    end
  end

  // sel=1 selects DIV, 0 selects MULT
  assign last = sel ? DIV_LAST : MULT_LAST;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sel_n   = sel;
    hi_n    = hi_out;
    lo_n    = lo_out;
    ua_n    = unit_a;
    ub_n    = unit_b;
    done_n  = 1'b0;
    dz_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          unique case (req_op)
            OP_MULT: begin
              ua_n    = op_a;
              ub_n    = op_b;
              sel_n   = 1'b0;
              state_n = ISSUE;
            end
            OP_DIV: begin
              if (op_b == '0) begin
                dz_n = 1'b1;
              end else begin
                ua_n    = op_a;
                ub_n    = op_b;
                sel_n   = 1'b1;
                state_n = ISSUE;
              end
            end
            OP_MTHI: begin
              hi_n   = op_a;
              done_n = 1'b1;
            end
            OP_MTLO: begin
              lo_n   = op_a;
              done_n = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ISSUE: begin
        cnt_n   = 6'd1;
        state_n = WAIT;
      end
      WAIT: begin
        if (cnt == last) begin
          state_n = CAPTURE;
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      CAPTURE: begin
        hi_n    = sel ? div_hi : mult_hi;
        lo_n    = sel ? div_lo : mult_lo;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign mult_start = (state == ISSUE) && !sel;
  assign div_start  = (state == ISSUE) && sel;

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer with fixed-latency MULT/DIV stubs.
module tb_hilo_sequencer;

  localparam int LAT = 34;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] op_a, op_b;
  logic [31:0] unit_a, unit_b;
  logic        mult_start, div_start;
  logic [31:0] mult_hi, mult_lo, div_hi, div_lo;
  logic        busy, done, div_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;
  int mk, dk;

  localparam logic [31:0] BAD = 32'hBAD0BAD0;

  hilo_sequencer #(.MULT_LAT(LAT), .DIV_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op(req_op),
    .op_a(op_a), .op_b(op_b),
    .unit_a(unit_a), .unit_b(unit_b),
    .mult_start(mult_start), .div_start(div_start),
    .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;

  // unit stubs: result appears exactly LAT cycles after the start cycle
  always @(posedge clock) begin
    if (reset) begin
      mk <= 0;
      mult_hi <= BAD;
      mult_lo <= BAD;
    end else if (mult_start) begin
      mk <= 1;
      mult_hi <= BAD;
      mult_lo <= BAD;
    end else if (mk != 0) begin
      mk <= (mk == LAT - 1) ? 0 : mk + 1;
      if (mk == LAT - 1)
        {mult_hi, mult_lo} <= $signed(unit_a) * $signed(unit_b);
    end
  end

  always @(posedge clock) begin
    if (reset) begin
      dk <= 0;
      div_hi <= BAD;
      div_lo <= BAD;
    end else if (div_start) begin
      dk <= 1;
      div_hi <= BAD;
      div_lo <= BAD;
    end else if (dk != 0) begin
      dk <= (dk == LAT - 1) ? 0 : dk + 1;
      if (dk == LAT - 1) begin
        div_hi <= $signed(unit_a) % $signed(unit_b);
        div_lo <= $signed(unit_a) / $signed(unit_b);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b);
    req_valid = 1'b1;
    req_op = op;
    op_a = a;
    op_b = b;
  endtask

  // full MULT/DIV from cycle 0 request to done at cycle 2+LAT
  task automatic long_op(input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [31:0] pre_hi,
                         input bit hold, input logic [31:0] hv);
    bit isdiv;
    isdiv = (op == 2'b01);
    req(op, a, b);
    tick();
    for (int c = 1; c <= 1 + LAT; c++) begin
      if (c == 1) begin
        req_valid = hold;
        req_op = 2'b10;
        op_a = hv;
        op_b = 32'h0;
      end
      chk($sformatf("busy@%0d", c), {31'b0, busy}, 32'd1);
      chk($sformatf("mstart@%0d", c), {31'b0, mult_start},
          {31'b0, (c == 1) && !isdiv});
      chk($sformatf("dstart@%0d", c), {31'b0, div_start},
          {31'b0, (c == 1) && isdiv});
      chk($sformatf("done@%0d", c), {31'b0, done}, 32'd0);
      chk($sformatf("hihold@%0d", c), hi_out, pre_hi);
      chk($sformatf("unit_a@%0d", c), unit_a, a);
      chk($sformatf("unit_b@%0d", c), unit_b, b);
      tick();
    end
    chk("done_end", {31'b0, done}, 32'd1);
    chk("busy_end", {31'b0, busy}, 32'd0);
    chk("hi_end", hi_out, ehi);
    chk("lo_end", lo_out, elo);
    if (!hold) req_valid = 1'b0;
    tick();
    req_valid = 1'b0;
    if (hold) begin
      chk("held_mthi_done", {31'b0, done}, 32'd1);
      chk("held_mthi_hi", hi_out, hv);
      chk("held_mthi_lo", lo_out, elo);
      tick();
    end
    chk("done_clear", {31'b0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_op = 2'b00;
    op_a = '0;
    op_b = '0;
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_dz", {31'b0, div_zero}, 32'd0);
    chk("rst_ms", {31'b0, mult_start}, 32'd0);
    chk("rst_ds", {31'b0, div_start}, 32'd0);
    chk("rst_hi", hi_out, 32'h0);
    chk("rst_lo", lo_out, 32'h0);
    chk("rst_ua", unit_a, 32'h0);
    chk("rst_ub", unit_b, 32'h0);
    reset = 1'b0;
    tick();

    // 1: MULT 7 * -3
    long_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB,
            32'h0, 1'b0, 32'h0);
    // 2: DIV 100 / 7
    long_op(2'b01, 32'd100, 32'd7, 32'd2, 32'd14,
            32'hFFFFFFFF, 1'b0, 32'h0);

    // 3: divide by zero with preloaded HI/LO
    req(2'b10, 32'h11, 32'h0);
    tick();
    req(2'b11, 32'h22, 32'h0);
    tick();
    req(2'b01, 32'd55, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("dz_pulse", {31'b0, div_zero}, 32'd1);
    chk("dz_busy", {31'b0, busy}, 32'd0);
    chk("dz_done", {31'b0, done}, 32'd0);
    chk("dz_ds", {31'b0, div_start}, 32'd0);
    chk("dz_hi", hi_out, 32'h11);
    chk("dz_lo", lo_out, 32'h22);
    chk("dz_ua", unit_a, 32'd100);
    chk("dz_ub", unit_b, 32'd7);
    tick();
    chk("dz_clear", {31'b0, div_zero}, 32'd0);
    chk("dz_busy2", {31'b0, busy}, 32'd0);
    chk("dz_ds2", {31'b0, div_start}, 32'd0);

    // 4: MTHI then MTLO back to back
    req(2'b10, 32'hDEADBEEF, 32'h0);
    tick();
    req(2'b11, 32'h12345678, 32'h0);
    chk("mthi_done", {31'b0, done}, 32'd1);
    chk("mthi_hi", hi_out, 32'hDEADBEEF);
    chk("mthi_lo", lo_out, 32'h22);
    chk("mthi_busy", {31'b0, busy}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("mtlo_done", {31'b0, done}, 32'd1);
    chk("mtlo_lo", lo_out, 32'h12345678);
    chk("mtlo_hi", hi_out, 32'hDEADBEEF);
    chk("mtlo_ua", unit_a, 32'd100);
    tick();
    chk("mt_done_clear", {31'b0, done}, 32'd0);

    // 5: MTHI held during MULT, accepted in done cycle
    req(2'b10, 32'h55, 32'h0);
    tick();
    req_valid = 1'b0;
    tick();
    long_op(2'b00, 32'd3, 32'd5, 32'h0, 32'd15,
            32'h55, 1'b1, 32'hDEADBEEF);

    // 6: reset mid-operation, then a fresh MULT
    req(2'b00, 32'd9, 32'd9);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_hi", hi_out, 32'h0);
    chk("mid_rst_lo", lo_out, 32'h0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_ua", unit_a, 32'h0);
    for (int c = 0; c < 30; c++) begin
      chk($sformatf("no_done@%0d", c), {31'b0, done}, 32'd0);
      chk($sformatf("no_busy@%0d", c), {31'b0, busy}, 32'd0);
      tick();
    end
    long_op(2'b00, 32'hFFFFFFFE, 32'hFFFFFFFC, 32'h0, 32'd8,
            32'h0, 1'b0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
